// File: rtl/sacred_const_arbiter.sv
// Round-robin arbiter sharing one sacred-constant ROM read port among NREQ requesters,
// with a single registered valid/ready response channel and a saturating served counter.

module kingdom_sacred_constants (
    output logic [63:0] phi,
    output logic [63:0] trinity
);
    assign phi     = 64'h3FF9_E377_9B97_F4A8;
    assign trinity = 64'h4008_0000_0000_0000;
endmodule

module sacred_const_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] idx,
    output logic [NREQ-1:0]   gnt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [63:0]       rsp_data,
    output logic [31:0]       served_cnt
);
    logic [63:0]    k_phi;
    logic [63:0]    k_trinity;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW:0]   ptr_inc;
    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] win_id;
    logic           win_found;
    logic [2:0]     sel_idx;
    logic [63:0]    rom_word;
    logic           can_issue;
    logic           grant;
    logic [31:0]    served_q;

    kingdom_sacred_constants u_consts (
        .phi     (k_phi),
        .trinity (k_trinity)
    );

    assign can_issue = !rsp_valid || rsp_ready;

    // Search ptr, ptr+1, ... wrapping at NREQ (which need not be a power of two).
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        sum       = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            cand = sum[IDW-1:0];
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // gnt is held low during reset even if requesters keep req asserted.
    assign grant = win_found && can_issue && !rst;

    always_comb begin
        gnt = '0;
        if (grant) begin
            gnt[win_id] = 1'b1;
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (IDW'(k) == win_id) begin
                sel_idx = idx[3*k +: 3];
            end
        end
    end

    always_comb begin
        case (sel_idx)
            3'd0:    rom_word = k_phi;
            3'd1:    rom_word = k_trinity;
            3'd2:    rom_word = 64'h4009_21FB_5444_2D18;
            3'd3:    rom_word = 64'h4005_BF0A_8B14_5769;
            3'd4:    rom_word = 64'h4004_F1BB_CDCB_FA54;
            3'd5:    rom_word = 64'h3FF0_0000_0000_0000;
            3'd6:    rom_word = 64'h4000_0000_0000_0000;
            default: rom_word = 64'h0000_0000_0000_0000;
        endcase
    end

    assign ptr_inc = {1'b0, win_id} + (IDW+1)'(1);
    assign ptr_nxt = (ptr_inc == (IDW+1)'(NREQ)) ? '0 : ptr_inc[IDW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            ptr       <= '0;
            served_q  <= '0;
        end else begin
            if (grant) begin
                rsp_valid <= 1'b1;
                rsp_id    <= win_id;
                rsp_data  <= rom_word;
                ptr       <= ptr_nxt;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (rsp_valid && rsp_ready && (served_q != '1)) begin
                served_q <= served_q + 32'd1;
            end
        end
    end

    assign served_cnt = served_q;

endmodule

// File: tb/tb_sacred_const_arbiter.sv
// Scoreboard bench for sacred_const_arbiter: tasks push expected responses at grant time,
// a negedge monitor pops and compares on every response handshake.

module tb_sacred_const_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] idx;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [63:0]       rsp_data;
    logic [31:0]       served_cnt;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [63:0]    data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    sacred_const_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .idx        (idx),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .served_cnt (served_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rom_model(input logic [2:0] i);
        case (i)
            3'd0:    return 64'h3FF9E3779B97F4A8;
            3'd1:    return 64'h4008000000000000;
            3'd2:    return 64'h400921FB54442D18;
            3'd3:    return 64'h4005BF0A8B145769;
            3'd4:    return 64'h4004F1BBCDCBFA54;
            3'd5:    return 64'h3FF0000000000000;
            3'd6:    return 64'h4000000000000000;
            default: return 64'h0000000000000000;
        endcase
    endfunction

    // Handshake completes at the following posedge; outputs are stable here.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got id=%0d data=%h, expected none", rsp_id, rsp_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rsp_id !== e.id || rsp_data !== e.data) begin
                    errors++;
                    $display("FAIL sb_rsp: got id=%0d data=%h, expected id=%0d data=%h",
                             rsp_id, rsp_data, e.id, e.data);
                end
            end
        end
    end

    task automatic go_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic go_sample();
        @(negedge clk);
    endtask

    task automatic push_exp(input int k);
        exp_t e;
        e.id   = IDW'(k);
        e.data = rom_model(idx[3*k +: 3]);
        sb.push_back(e);
    endtask

    task automatic do_reset();
        go_drive();
        rst = 1'b1;
        sb.delete();
        req = '0;
        rsp_ready = 1'b1;
        go_drive();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        idx = '0;
        rsp_ready = 1'b1;
        go_sample();
        go_sample();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0 || served_cnt !== '0 || gnt !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b id=%0d data=%h cnt=%h gnt=%b, expected all zero",
                     rsp_valid, rsp_id, rsp_data, served_cnt, gnt);
        end
        go_drive();
        rst = 1'b0;
        req = 4'b0001;
        idx[2:0] = 3'd0;
        go_sample();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_gnt: got %b, expected 0001", gnt);
        end
        push_exp(0);
        go_drive();
        req = '0;
        go_sample();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 64'h3FF9E3779B97F4A8) begin
            errors++;
            $display("FAIL reset_first_rsp: got valid=%b id=%0d data=%h, expected 1 0 3ff9e3779b97f4a8",
                     rsp_valid, rsp_id, rsp_data);
        end
        go_drive();
        go_sample();
        checks++;
        if (served_cnt !== 32'd1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_retire: got cnt=%0d valid=%b, expected 1 0", served_cnt, rsp_valid);
        end
    endtask

    task automatic test_rom_sweep();
        do_reset();
        req = 4'b0100;
        for (int v = 0; v < 8; v++) begin
            idx[8:6] = 3'(v);
            go_sample();
            checks++;
            if (gnt !== 4'b0100) begin
                errors++;
                $display("FAIL sweep_gnt[%0d]: got %b, expected 0100", v, gnt);
            end
            push_exp(2);
            go_drive();
        end
        req = '0;
        go_sample();
        go_drive();
        go_sample();
        checks++;
        if (served_cnt !== 32'd8) begin
            errors++;
            $display("FAIL sweep_cnt: got %0d, expected 8", served_cnt);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        for (int k = 0; k < NREQ; k++) idx[3*k +: 3] = 3'(k + 2);
        req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            logic [NREQ-1:0] want;
            want = '0;
            want[i % NREQ] = 1'b1;
            go_sample();
            checks++;
            if (gnt !== want) begin
                errors++;
                $display("FAIL rotation_gnt[%0d]: got %b, expected %b", i, gnt, want);
            end
            push_exp(i % NREQ);
            go_drive();
        end
        req = '0;
        go_sample();
        go_drive();
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 4'b0001;
        idx[2:0] = 3'd2;
        go_sample();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL bp_first_gnt: got %b, expected 0001", gnt);
        end
        push_exp(0);
        go_drive();
        req = 4'b0010;
        idx[5:3] = 3'd3;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            go_sample();
            checks++;
            if (gnt !== '0) begin
                errors++;
                $display("FAIL bp_gnt[%0d]: got %b, expected 0000", i, gnt);
            end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 64'h400921FB54442D18 || served_cnt !== 32'd0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b id=%0d data=%h cnt=%0d, expected 1 0 400921fb54442d18 0",
                         i, rsp_valid, rsp_id, rsp_data, served_cnt);
            end
            go_drive();
        end
        rsp_ready = 1'b1;
        go_sample();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release_gnt: got %b, expected 0010", gnt);
        end
        push_exp(1);
        go_drive();
        req = '0;
        go_sample();
        go_drive();
        go_sample();
        checks++;
        if (served_cnt !== 32'd2) begin
            errors++;
            $display("FAIL bp_cnt: got %0d, expected 2", served_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < NREQ; k++) idx[3*k +: 3] = 3'd5;
        req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            go_sample();
            push_exp(i % NREQ);
            go_drive();
        end
        checks++;
        if (served_cnt !== 32'd5 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre: got cnt=%0d valid=%b, expected 5 1", served_cnt, rsp_valid);
        end
        #2;
        rst = 1'b1;
        sb.delete();
        req = 4'b1010;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || served_cnt !== '0 || rsp_data !== '0 || rsp_id !== '0 || gnt !== '0) begin
            errors++;
            $display("FAIL ar_clear: got valid=%b cnt=%h data=%h id=%0d gnt=%b, expected all zero",
                     rsp_valid, served_cnt, rsp_data, rsp_id, gnt);
        end
        go_drive();
        go_drive();
        rst = 1'b0;
        idx[5:3]  = 3'd6;
        idx[11:9] = 3'd7;
        go_sample();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL ar_gnt_low: got %b, expected 0010", gnt);
        end
        push_exp(1);
        go_drive();
        req = 4'b1000;
        go_sample();
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL ar_gnt_req3: got %b, expected 1000", gnt);
        end
        push_exp(3);
        go_drive();
        req = '0;
        go_sample();
        go_drive();
    endtask

    task automatic test_saturation();
        do_reset();
        dut.served_q = 32'hFFFF_FFFE;
        req = 4'b0001;
        idx[2:0] = 3'd5;
        for (int i = 0; i < 3; i++) begin
            go_sample();
            checks++;
            if (gnt !== 4'b0001) begin
                errors++;
                $display("FAIL sat_gnt[%0d]: got %b, expected 0001", i, gnt);
            end
            push_exp(0);
            go_drive();
        end
        req = '0;
        go_sample();
        go_drive();
        go_drive();
        go_sample();
        checks++;
        if (served_cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sat_cnt: got %h, expected ffffffff", served_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        idx = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_rom_sweep();
        test_rotation();
        test_backpressure();
        test_async_reset();
        test_saturation();
        go_sample();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d outstanding, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sacred_const_arbiter.md
# sacred_const_arbiter

Round-robin arbiter and response pipeline that shares one sacred-constant ROM read port among `NREQ` requesters. Each requester raises a request with a 3-bit constant index. The block grants one requester per cycle, reads the selected IEEE-754 double, and returns it on a single registered response channel with valid/ready backpressure. It sits between the compute kingdoms and the sacred constants layer. ROM entries 0 and 1 come from an internal `kingdom_sacred_constants` instance (`phi`, `trinity`).

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default 2: requester-id width, equal to clog2(`NREQ`).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `req`  in  `NREQ`: per-requester request. Held high with `idx` stable until the matching `gnt`.
- `idx`  in  3*`NREQ`: constant index; requester k uses bits [3k+2:3k].
- `gnt`  out  `NREQ`: one-hot grant, combinational, at most one bit high.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_id`  out  `IDW`: requester that the response belongs to.
- `rsp_data`  out  64: constant value, IEEE-754 binary64.
- `served_cnt`  out  32: number of completed response handshakes, saturating.

## Operation
- ROM map (index: word):
  - 0: phi `3FF9E3779B97F4A8`
  - 1: trinity `4008000000000000`
  - 2: pi `400921FB54442D18`
  - 3: e `4005BF0A8B145769`
  - 4: phi² `4004F1BBCDCBFA54`
  - 5: 1.0 `3FF0000000000000`
  - 6: 2.0 `4000000000000000`
  - 7: 0.0 `0000000000000000`
- Round-robin pointer `ptr` (`IDW` bits, reset 0):
  - Search order is `ptr`, `ptr`+1, … modulo `NREQ`.
  - The first requester with `req` high wins.
- `can_issue = !rsp_valid || rsp_ready`.
  - `gnt[k]` is high only if `can_issue` and k is the winner.
  - With no requests or `!can_issue`, `gnt` = 0.
- On a clock edge with a grant to requester k:
  - `rsp_data` ← ROM[`idx` of k].
  - `rsp_id` ← k.
  - `rsp_valid` ← 1.
  - `ptr` ← (k+1) mod `NREQ`.
- On a clock edge with no grant, `rsp_valid && rsp_ready` sets `rsp_valid` ← 0.
- While `rsp_valid && !rsp_ready`:
  - `rsp_data` and `rsp_id` stay stable.
  - `ptr` is frozen.
  - No grants are issued.
- `served_cnt` increments on every edge where `rsp_valid && rsp_ready`. It saturates at `FFFFFFFF`.
- A requester dropping `req` before its grant is legal. It simply loses arbitration; there is no error state.

## Timing
- Reset values: `rsp_valid` 0, `rsp_id` 0, `rsp_data` 0, `served_cnt` 0, `ptr` 0, `gnt` 0.
- Reset acts immediately, without waiting for a clock edge.
- Latency: a grant in cycle t produces `rsp_valid` = 1 in cycle t+1.
- Throughput: one response per cycle when `rsp_ready` is held high. A grant and a retire in the same cycle keep `rsp_valid` high with the new data.
- Simultaneous requests are served strictly in rotation starting from `ptr`. A requester holding `req` is served within `NREQ` grants.
- Single requester, `req` held: it is granted every cycle while `can_issue`.
- Reset mid-operation: any pending response is discarded, `ptr` returns to 0, and `served_cnt` is cleared. Requesters must re-request after reset is released.
- The first grant can occur in the first cycle after `rst` falls.

## Test plan
- Reset check: after `rst`, all outputs are 0. Requester 0 with `req[0]`=1, `idx`=0 gets `gnt`=0001 in the first cycle. The next cycle shows `rsp_valid`=1, `rsp_id`=0, `rsp_data`=`3FF9E3779B97F4A8`.
- ROM sweep: requester 2 issues `idx` 0..7 back-to-back with `rsp_ready`=1. The bench sees 8 consecutive responses matching the ROM map exactly, including `4008000000000000` for index 1. `served_cnt` ends at 8.
- Rotation: all four `req` held high, `ptr`=0, `rsp_ready`=1. Grants are 0,1,2,3,0,1 on consecutive cycles, and `rsp_id` follows one cycle later.
- Backpressure: `rsp_ready`=0 for 3 cycles while a response is valid. `gnt`=0, `rsp_data`/`rsp_id` are stable, and `served_cnt` is unchanged. On the cycle `rsp_ready`=1, the next requester is granted in the same cycle.
- Async reset mid-stream: assert `rst` between clock edges while `rsp_valid`=1 and `served_cnt`=5. Outputs clear at once. After release, requester 3 (`req` held) is granted only after any lower requesters, counting from `ptr`=0.
- Saturation: force `served_cnt` near max (bench preload via hierarchical deposit to `FFFFFFFE`) and complete 3 handshakes. The count reads `FFFFFFFF` and holds.
